// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode 7-segment driver: shadowed BCD digits, leading-zero
// blanking, inter-digit anode guard window and an end-of-frame strobe.
module seg7_scan_driver #(
  parameter int DIGITS         = 4,
  parameter int SCAN_DIV       = 50000,
  parameter int BLANK_CYC      = 2,
  parameter int LZ_BLANK       = 1,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [4*DIGITS-1:0]   IN,
  input  logic [DIGITS-1:0]     DP,
  input  logic                  LOAD,
  input  logic                  EN,
  output logic [6:0]            SEG,
  output logic                  DP_OUT,
  output logic [DIGITS-1:0]     AN,
  output logic                  FRAME
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0]     CNT_LAST  = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0]     CNT_GUARD = CW'(BLANK_CYC);
  localparam logic [DW-1:0]     DIG_LAST  = DW'(DIGITS - 1);
  localparam logic              SEG_LOW   = (SEG_ACTIVE_LOW != 0);
  localparam logic              AN_LOW    = (AN_ACTIVE_LOW != 0);
  localparam logic [6:0]        SEG_OFF   = {7{SEG_LOW}};
  localparam logic [DIGITS-1:0] AN_OFF    = {DIGITS{AN_LOW}};

  logic [CW-1:0]       cnt, cnt_nx;
  logic [DW-1:0]       d, d_nx;
  logic [4*DIGITS-1:0] sh_in;
  logic [DIGITS-1:0]   sh_dp;
  logic [DIGITS-1:0]   blank;
  logic                zero_above;
  logic [3:0]          cur_code;
  logic                cur_blank, cur_dp;
  logic [6:0]          seg_raw, seg_nx;
  logic                dp_nx, frame_nx;
  logic [DIGITS-1:0]   an_nx;

  // Active-low segment patterns {g,f,e,d,c,b,a}.
  function automatic logic [6:0] decode(input logic [3:0] v);
    case (v)
      4'd0:    decode = 7'b1000000;
      4'd1:    decode = 7'b1111001;
      4'd2:    decode = 7'b0100100;
      4'd3:    decode = 7'b0110000;
      4'd4:    decode = 7'b0011001;
      4'd5:    decode = 7'b0010010;
      4'd6:    decode = 7'b0000010;
      4'd7:    decode = 7'b1111000;
      4'd8:    decode = 7'b0000000;
      4'd9:    decode = 7'b0010000;
      default: decode = 7'b1111111;
    endcase
  endfunction

  // Walk from the most significant digit down; blanking stops at the first non-zero.
  always_comb begin
    blank      = '0;
    zero_above = 1'b1;
    for (int unsigned j = 0; j < DIGITS; j++) begin
      zero_above = zero_above & (sh_in[4*(DIGITS-1-j) +: 4] == 4'd0);
      blank[DIGITS-1-j] = (LZ_BLANK != 0) && (j != DIGITS - 1) && zero_above;
    end
  end

  always_comb begin
    cur_code  = 4'd0;
    cur_blank = 1'b0;
    cur_dp    = 1'b0;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      if (d == DW'(k)) begin
        cur_code  = sh_in[4*k +: 4];
        cur_blank = blank[k];
        cur_dp    = sh_dp[k];
      end
    end
  end

  always_comb begin
    cnt_nx = cnt + 1'b1;
    d_nx   = d;
    if (cnt == CNT_LAST) begin
      cnt_nx = '0;
      d_nx   = (d == DIG_LAST) ? '0 : d + 1'b1;
    end
  end

  always_comb begin
    seg_raw  = cur_blank ? 7'b1111111 : decode(cur_code);
    seg_nx   = SEG_LOW ? seg_raw : ~seg_raw;
    dp_nx    = SEG_LOW ? ~cur_dp : cur_dp;
    frame_nx = (cnt == CNT_LAST) && (d == DIG_LAST);
    an_nx    = AN_OFF;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      an_nx[k] = (EN && (cnt >= CNT_GUARD) && (d == DW'(k))) ^ AN_LOW;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt    <= '0;
      d      <= '0;
      sh_in  <= '0;
      sh_dp  <= '0;
      SEG    <= SEG_OFF;
      DP_OUT <= SEG_LOW;
      AN     <= AN_OFF;
      FRAME  <= 1'b0;
    end else begin
      cnt    <= cnt_nx;
      d      <= d_nx;
      if (LOAD) begin
        sh_in <= IN;
        sh_dp <= DP;
      end
      SEG    <= seg_nx;
      DP_OUT <= dp_nx;
      AN     <= an_nx;
      FRAME  <= frame_nx;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver: stimulus schedules expected outputs per cycle,
// a negedge monitor pops and compares them. Three instances cover LZ on/off and 1-digit.
module tb_seg7_scan_driver;

  logic        clk = 1'b0;
  logic        RST, LOAD, EN;
  logic [15:0] IN;
  logic [3:0]  DP;

  logic [6:0] seg0, seg1, seg2;
  logic       dpo0, dpo1, dpo2;
  logic [3:0] an0, an1;
  logic       an2;
  logic       fr0, fr1, fr2;

  int cyc = 0, base = 0, checks = 0, errors = 0;

  typedef struct {
    int         cyc;
    int         inst;
    string      name;
    logic [3:0] msk;   // {an, seg, dp, frame}
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       fr;
  } exp_t;
  exp_t sb[$];

  seg7_scan_driver #(.DIGITS(4), .SCAN_DIV(4), .BLANK_CYC(1), .LZ_BLANK(1),
                     .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)) u0 (
    .CLK(clk), .RST(RST), .IN(IN), .DP(DP), .LOAD(LOAD), .EN(EN),
    .SEG(seg0), .DP_OUT(dpo0), .AN(an0), .FRAME(fr0));

  seg7_scan_driver #(.DIGITS(4), .SCAN_DIV(4), .BLANK_CYC(1), .LZ_BLANK(0),
                     .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)) u1 (
    .CLK(clk), .RST(RST), .IN(IN), .DP(DP), .LOAD(LOAD), .EN(EN),
    .SEG(seg1), .DP_OUT(dpo1), .AN(an1), .FRAME(fr1));

  seg7_scan_driver #(.DIGITS(1), .SCAN_DIV(2), .BLANK_CYC(1), .LZ_BLANK(1),
                     .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)) u2 (
    .CLK(clk), .RST(RST), .IN(IN[3:0]), .DP(DP[0]), .LOAD(LOAD), .EN(EN),
    .SEG(seg2), .DP_OUT(dpo2), .AN(an2), .FRAME(fr2));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic push(input int c, input int inst, input string name, input logic [3:0] msk,
                      input logic [7:0] an, input logic [6:0] seg, input logic dp, input logic fr);
    exp_t e;
    e.cyc = c; e.inst = inst; e.name = name; e.msk = msk;
    e.an = an; e.seg = seg; e.dp = dp; e.fr = fr;
    sb.push_back(e);
  endtask

  // First future cycle whose output reflects slot (dd, cc) of the 4x4 scan.
  function automatic int next_obs(input int dd, input int cc);
    int c;
    c = base + 1 + dd*4 + cc;
    while (c <= cyc) c += 16;
    return c;
  endfunction

  task automatic check_one(input exp_t e);
    logic [7:0] a_an;
    logic [6:0] a_seg;
    logic       a_dp, a_fr;
    case (e.inst)
      0:       begin a_an = {4'b0, an0}; a_seg = seg0; a_dp = dpo0; a_fr = fr0; end
      1:       begin a_an = {4'b0, an1}; a_seg = seg1; a_dp = dpo1; a_fr = fr1; end
      default: begin a_an = {7'b0, an2}; a_seg = seg2; a_dp = dpo2; a_fr = fr2; end
    endcase
    if (e.msk[3]) begin
      checks++;
      if (a_an !== e.an) begin
        errors++;
        $display("FAIL %s cyc %0d AN got %b want %b", e.name, cyc, a_an, e.an);
      end
    end
    if (e.msk[2]) begin
      checks++;
      if (a_seg !== e.seg) begin
        errors++;
        $display("FAIL %s cyc %0d SEG got %b want %b", e.name, cyc, a_seg, e.seg);
      end
    end
    if (e.msk[1]) begin
      checks++;
      if (a_dp !== e.dp) begin
        errors++;
        $display("FAIL %s cyc %0d DP_OUT got %b want %b", e.name, cyc, a_dp, e.dp);
      end
    end
    if (e.msk[0]) begin
      checks++;
      if (a_fr !== e.fr) begin
        errors++;
        $display("FAIL %s cyc %0d FRAME got %b want %b", e.name, cyc, a_fr, e.fr);
      end
    end
  endtask

  always @(negedge clk) begin
    int i;
    i = 0;
    while (i < sb.size()) begin
      if (sb[i].cyc == cyc) begin
        check_one(sb[i]);
        sb.delete(i);
      end else if (sb[i].cyc < cyc) begin
        checks++;
        errors++;
        $display("FAIL %s stale: due cyc %0d, now %0d", sb[i].name, sb[i].cyc, cyc);
        sb.delete(i);
      end else begin
        i++;
      end
    end
  end

  task automatic load(input logic [15:0] v, input logic [3:0] p);
    @(negedge clk);
    IN = v; DP = p; LOAD = 1'b1;
    @(negedge clk);
    LOAD = 1'b0;
    @(negedge clk);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations pending, want 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic wait_phase(input int m, input int v);
    int n;
    n = 0;
    while (((cyc - base) % m) != v && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (((cyc - base) % m) != v) begin
      checks++;
      errors++;
      $display("FAIL phase: got %0d want %0d", (cyc - base) % m, v);
    end
  endtask

  task automatic push_digits(input int inst, input string name, input logic [3:0] msk,
                             input logic [6:0] s0, input logic [6:0] s1, input logic [6:0] s2,
                             input logic [6:0] s3, input logic [3:0] dpx);
    logic [6:0] st [4];
    st = '{s0, s1, s2, s3};
    for (int k = 0; k < 4; k++)
      push(next_obs(k, 2), inst, name, msk, 8'h0F ^ (8'h01 << k), st[k], dpx[k], 1'b0);
  endtask

  task automatic push_corner_toggle();
    for (int c = base + 1; c <= base + 6; c++) begin
      logic act;
      act = ((c - base - 1) % 2) == 1;
      push(c, 2, "c_toggle", 4'b1101, act ? 8'h00 : 8'h01, 7'h40, 1'b1, act);
    end
  endtask

  initial begin
    int f, dcur;
    RST = 1'b1; LOAD = 1'b0; EN = 1'b1; IN = '0; DP = '0;

    // Reset and first anode
    @(negedge clk);
    push(2, 0, "rst", 4'hF, 8'h0F, 7'h7F, 1'b1, 1'b0);
    push(3, 0, "rst", 4'hF, 8'h0F, 7'h7F, 1'b1, 1'b0);
    push(2, 2, "c_rst", 4'hF, 8'h01, 7'h7F, 1'b1, 1'b0);
    @(negedge clk);
    @(negedge clk);
    RST = 1'b0;
    base = cyc;
    push(base + 1, 0, "rel_gap", 4'b1001, 8'h0F, 7'h00, 1'b0, 1'b0);
    for (int c = base + 2; c <= base + 4; c++)
      push(c, 0, "first_an", 4'b1001, 8'h0E, 7'h00, 1'b0, 1'b0);
    push(base + 2, 0, "first_seg", 4'b0110, 8'h00, 7'h40, 1'b1, 1'b0);
    push(base + 5, 0, "guard", 4'b1001, 8'h0F, 7'h00, 1'b0, 1'b0);
    push(base + 6, 0, "dig1", 4'b1001, 8'h0D, 7'h00, 1'b0, 1'b0);
    push_corner_toggle();
    drain();

    // Full digit set and frame period
    load(16'h1234, 4'b0100);
    push_digits(0, "digits", 4'b1110, 7'h19, 7'h30, 7'h24, 7'h79, 4'b1011);
    push(next_obs(3, 0), 0, "guard_seg", 4'b1100, 8'h0F, 7'h79, 1'b0, 1'b0);
    f = next_obs(3, 3);
    push(f,      0, "frame",  4'b1001, 8'h07, 7'h00, 1'b0, 1'b1);
    push(f + 1,  0, "frame0", 4'b0001, 8'h00, 7'h00, 1'b0, 1'b0);
    push(f + 8,  0, "frame0", 4'b0001, 8'h00, 7'h00, 1'b0, 1'b0);
    push(f + 16, 0, "frame",  4'b0001, 8'h00, 7'h00, 1'b0, 1'b1);
    push(cyc + 1, 2, "c_seg", 4'b0100, 8'h00, 7'h19, 1'b0, 1'b0);
    drain();

    // Leading-zero blanking
    load(16'h0050, 4'b0000);
    push_digits(0, "lz_0050", 4'b1110, 7'h40, 7'h12, 7'h7F, 7'h7F, 4'b1111);
    drain();
    load(16'h0000, 4'b1000);
    push_digits(0, "lz_zero", 4'b1110, 7'h40, 7'h7F, 7'h7F, 7'h7F, 4'b0111);
    push_digits(1, "nolz_zero", 4'b0110, 7'h40, 7'h40, 7'h40, 7'h40, 4'b0111);
    drain();

    // Invalid code, EN drop and resume
    load(16'h0B07, 4'b0000);
    push_digits(0, "invalid", 4'b1100, 7'h78, 7'h40, 7'h7F, 7'h7F, 4'b1111);
    push(cyc + 1, 2, "c_seg", 4'b0100, 8'h00, 7'h78, 1'b0, 1'b0);
    drain();
    wait_phase(4, 2);
    EN = 1'b0;
    push(cyc + 1, 0, "en_off", 4'b1000, 8'h0F, 7'h00, 1'b0, 1'b0);
    push(cyc + 2, 0, "en_off", 4'b1000, 8'h0F, 7'h00, 1'b0, 1'b0);
    f = next_obs(3, 3);
    push(f,      0, "en_frame", 4'b1001, 8'h0F, 7'h00, 1'b0, 1'b1);
    push(f + 16, 0, "en_frame", 4'b1001, 8'h0F, 7'h00, 1'b0, 1'b1);
    drain();
    wait_phase(4, 2);
    dcur = ((cyc - base) / 4) % 4;
    EN = 1'b1;
    push(cyc + 1, 0, "en_on", 4'b1000, 8'h0F ^ (8'h01 << dcur), 7'h00, 1'b0, 1'b0);
    drain();

    // LOAD while digit 0 is active: one-cycle update latency
    wait_phase(16, 1);
    IN = 16'h0009; LOAD = 1'b1;
    push(cyc + 1, 0, "ld_old", 4'b1100, 8'h0E, 7'h78, 1'b0, 1'b0);
    push(cyc + 2, 0, "ld_new", 4'b1100, 8'h0E, 7'h10, 1'b0, 1'b0);
    @(negedge clk);
    LOAD = 1'b0;
    drain();

    // LOAD together with RST: reset wins
    @(negedge clk);
    IN = 16'h1234; DP = 4'b1111; LOAD = 1'b1; RST = 1'b1;
    push(cyc + 1, 0, "ld_rst", 4'hF, 8'h0F, 7'h7F, 1'b1, 1'b0);
    push(cyc + 1, 2, "c_ld_rst", 4'hF, 8'h01, 7'h7F, 1'b1, 1'b0);
    @(negedge clk);
    RST = 1'b0; LOAD = 1'b0;
    base = cyc;
    push(base + 2, 0, "rst_shadow", 4'b1110, 8'h0E, 7'h40, 1'b1, 1'b0);
    push(next_obs(1, 2), 0, "rst_shadow", 4'b1100, 8'h0D, 7'h7F, 1'b0, 1'b0);
    push(next_obs(1, 2), 1, "rst_shadow_nolz", 4'b0100, 8'h00, 7'h40, 1'b0, 1'b0);
    push_corner_toggle();
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
